// File: rtl/rr_mux16_arbiter_if.sv
// rr_mux16_arbiter_if: request/grant bundle between requesters and the mux16 arbiter
interface rr_mux16_arbiter_if;
   logic [15:0] req;
   logic        done;
   logic [15:0] grant;
   logic        grant_valid;
   logic [3:0]  sel;
   logic        timeout;
   modport master (output req, done, input grant, grant_valid, sel, timeout);
   modport slave  (input req, done, output grant, grant_valid, sel, timeout);
endinterface

// File: rtl/rr_mux16_arbiter.sv
// rr_mux16_arbiter: round-robin arbiter with hold timeout driving a shared mux16 select
module rr_mux16_arbiter #(
   parameter int N        = 16,
   parameter int SEL_W    = 4,
   parameter int MAX_HOLD = 15
) (
   input logic clk,
   input logic rst_n,
   rr_mux16_arbiter_if.slave bus
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t           state;
   logic [SEL_W-1:0] ptr, win, idx;
   logic [3:0]       cnt;
   logic             found, rel, to;
   // ptr is refreshed at every grant, so it is already sel+1 whenever a release occurs
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int i = N-1; i >= 0; i--) begin
         idx = ptr + SEL_W'(i);
         if (bus.req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end
   assign to  = state == BUSY && !bus.done && bus.req[bus.sel] && cnt == 4'(MAX_HOLD);
   assign rel = state == BUSY && (bus.done || !bus.req[bus.sel] || cnt == 4'(MAX_HOLD));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         ptr             <= '0;
         cnt             <= '0;
         bus.grant       <= '0;
         bus.grant_valid <= 1'b0;
         bus.sel         <= '0;
         bus.timeout     <= 1'b0;
      end else begin
         bus.timeout <= to;
         if (state == IDLE || rel) begin
            if (found) begin
               state           <= BUSY;
               bus.grant       <= N'(1) << win;
               bus.grant_valid <= 1'b1;
               bus.sel         <= win;
               ptr             <= win + SEL_W'(1);
               cnt             <= 4'd1;
            end else begin
               state           <= IDLE;
               bus.grant       <= '0;
               bus.grant_valid <= 1'b0;
            end
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_rr_mux16_arbiter.sv
// tb_rr_mux16_arbiter: directed vectors with hand-computed grants for the round-robin arbiter
module tb_rr_mux16_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   rr_mux16_arbiter_if bus ();
   rr_mux16_arbiter #(.N(16), .SEL_W(4), .MAX_HOLD(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_grant(input string tag, input logic [15:0] g, input logic [3:0] s);
      chk({tag, "_grant"}, 32'(bus.grant), 32'(g));
      chk({tag, "_sel"}, 32'(bus.sel), 32'(s));
      chk({tag, "_valid"}, 32'(bus.grant_valid), 32'(g != 0));
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   logic [15:0] rot_g [4] = '{16'h0020, 16'h0400, 16'h8000, 16'h0001};
   logic [3:0]  rot_s [4] = '{4'd5, 4'd10, 4'd15, 4'd0};

   initial begin
      bus.req  = 16'hFFFF;
      bus.done = 1'b0;
      tick();
      tick();
      expect_grant("rst", 16'h0000, 4'd0);
      chk("rst_timeout", 32'(bus.timeout), 32'd0);
      rst_n = 1'b1;
      tick();
      expect_grant("first", 16'h0001, 4'd0);

      do_reset();
      bus.req = 16'h8421;
      tick();
      expect_grant("rot0", 16'h0001, 4'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         tick();
         expect_grant("rot_hold", rot_g[(k+3)%4], rot_s[(k+3)%4]);
         bus.done = 1'b1;
         tick();
         bus.done = 1'b0;
         expect_grant("rot", rot_g[k], rot_s[k]);
      end

      do_reset();
      bus.req = 16'h0018;
      tick();
      expect_grant("b2b_first", 16'h0008, 4'd3);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      expect_grant("b2b_next", 16'h0010, 4'd4);

      do_reset();
      bus.req = 16'h0002;
      tick();
      expect_grant("to_start", 16'h0002, 4'd1);
      for (int k = 2; k <= 4; k++) begin
         tick();
         chk("to_early", 32'(bus.timeout), 32'd0);
      end
      tick();
      chk("to_pulse", 32'(bus.timeout), 32'd1);
      expect_grant("to_regrant", 16'h0002, 4'd1);
      tick();
      chk("to_clear", 32'(bus.timeout), 32'd0);
      expect_grant("to_held", 16'h0002, 4'd1);

      do_reset();
      bus.req = 16'h0080;
      tick();
      expect_grant("wd_first", 16'h0080, 4'd7);
      bus.req = 16'h0200;
      tick();
      expect_grant("wd_next", 16'h0200, 4'd9);
      chk("wd_timeout", 32'(bus.timeout), 32'd0);
      bus.req = 16'h0000;
      tick();
      expect_grant("wd_idle", 16'h0000, 4'd9);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      expect_grant("idle_done", 16'h0000, 4'd9);

      do_reset();
      bus.req = 16'h0040;
      tick();
      expect_grant("ar_first", 16'h0040, 4'd6);
      #2;
      rst_n = 1'b0;
      #1;
      expect_grant("ar_async", 16'h0000, 4'd0);
      rst_n = 1'b1;
      bus.req = 16'h0041;
      tick();
      expect_grant("ar_after", 16'h0001, 4'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rr_mux16_arbiter.md
Name: rr_mux16_arbiter

Overview:
- Round-robin arbiter that shares one 16:1 bit-select datapath (mux16) among 16 requesters.
- Produces a registered one-hot grant and the matching 4-bit encoded select, which drives the mux16 sel input directly.
- Holds each grant until the grantee signals done, drops its request, or exceeds a hold timeout.
- Sits between the requesting units and the shared mux16/adder operand path.

Parameters:
- N, 16, number of requesters; fixed at 16 to match the mux16 select width.
- SEL_W, 4, width of the encoded select; must equal log2(N).
- MAX_HOLD, 15, maximum number of cycles a grant may be held. Counter width is 4 bits; legal range is 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  16  per-requester request, level-sensitive
- done  input  1  single-cycle pulse from the current grantee: transfer finished
- grant  output  16  registered one-hot grant; all zeros when idle
- grant_valid  output  1  high while any grant bit is set
- sel  output  4  binary index of the current or most recent grantee; feeds the mux16 sel input
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked by the hold timeout

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - grant=0, grant_valid=0, sel=0, timeout=0
  - priority pointer ptr=0, hold counter cnt=0, state=IDLE
- Reset asserted mid-grant clears everything immediately, without waiting for a clock edge.
- Arbitration function:
  - Scan req starting at index ptr, then ptr+1, and so on, wrapping modulo 16.
  - The first set bit wins.
  - ptr always points one past the last grantee.
- State IDLE:
  - At a clock edge with any req bit high: register the winner into grant, set sel to its index, set cnt=1, go to BUSY.
  - Latency is 1 cycle: a req sampled at edge t gives a grant visible after edge t.
  - With req=0: stay in IDLE; sel holds its last value so the mux output stays stable.
- State BUSY, release conditions (evaluated each edge, in priority order):
  1. done=1: normal release.
  2. req[sel]=0 (grantee withdrew): abort release. No timeout pulse.
  3. cnt==MAX_HOLD and neither of the above: forced release, timeout=1 for exactly one cycle.
- Otherwise in BUSY: cnt increments by 1 and grant stays unchanged.
- On any release:
  - ptr becomes (sel+1) mod 16; index 15 wraps to 0.
  - The new arbitration is evaluated in the same edge using the updated ptr and the current req.
  - If any req bit is high: grant goes back-to-back to the winner with no idle cycle, cnt=1, stay in BUSY. The previous grantee can win again only if it is the sole requester.
  - If no req bit is high: grant=0, go to IDLE.
- done while in IDLE is ignored.
- Requests from non-granted requesters never disturb the current grant.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid equals the OR-reduction of grant.
  - Whenever grant_valid=1, sel equals the encoded index of grant.
- All outputs are registered; there are no combinational paths from input to output.

Test Plan:
- Reset check: drive rst_n low with req=16'hFFFF -> grant=0, sel=0, timeout=0. After release, the first edge gives grant=16'h0001, sel=0.
- Round-robin rotation: hold req=16'h8421 and pulse done every 3rd cycle -> grant sequence 0x0001, 0x0020, 0x0400, 0x8000, 0x0001 (wrap), with sel 0, 5, 10, 15, 0.
- Back-to-back handoff: start with grantee 3, req=16'h0018, pulse done -> the next cycle shows grant=0x0010, sel=4, with no cycle where grant_valid=0.
- Timeout: MAX_HOLD=4, req=16'h0002, never pulse done -> grant held for 4 cycles, then timeout pulses for 1 cycle. The grant is immediately re-issued to 0x0002 with cnt=1.
- Withdrawal: grantee 7 drops req[7] while req[9]=1 -> the next edge gives grant=0x0200, sel=9, timeout=0. Then drop all requests -> grant=0 and sel holds 9.
- Asynchronous reset mid-grant: assert rst_n low between clock edges while grant=0x0040 -> grant=0 and sel=0 immediately. After release, ptr=0, so req=16'h0041 grants 0x0001.
